// File: rtl/usb_rx_bit_sampler.sv
// usb_rx_bit_sampler: edge re-phased mid-bit sampling, NRZI decode and bit unstuffing
// for the USB receive path; emits per-bit and per-byte strobes plus a sticky stuff error.
module usb_rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_edge,
  input  logic rcving,
  output logic d_orig,
  output logic bit_valid,
  output logic byte_received,
  output logic stuff_err
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  logic [PW-1:0] r_phase;
  logic          r_prev;
  logic [OW-1:0] r_ones;
  logic [2:0]    r_bit_cnt;
  logic          w_sample;
  logic          w_dec;
  logic          w_full;
  assign w_sample = r_phase == PW'(SAMPLE_POINT);
  assign w_dec    = ~(d_plus_sync ^ r_prev);
  assign w_full   = r_ones == OW'(STUFF_LIMIT);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase       <= '0;
      r_prev        <= 1'b1;
      r_ones        <= '0;
      r_bit_cnt     <= '0;
      d_orig        <= 1'b1;
      bit_valid     <= 1'b0;
      byte_received <= 1'b0;
      stuff_err     <= 1'b0;
    end else if (!rcving) begin
      r_phase       <= '0;
      r_prev        <= 1'b1;
      r_ones        <= '0;
      r_bit_cnt     <= '0;
      d_orig        <= 1'b1;
      bit_valid     <= 1'b0;
      byte_received <= 1'b0;
      stuff_err     <= 1'b0;
    end else begin
      r_phase       <= (d_edge || r_phase == PW'(CLKS_PER_BIT - 1)) ? '0 : r_phase + 1'b1;
      bit_valid     <= 1'b0;
      byte_received <= 1'b0;
      if (w_sample) begin
        r_prev <= d_plus_sync;
        // a full run of ones means this bit is either the stuffed zero or a violation
        if (w_full && !w_dec)
          r_ones <= '0;
        else if (w_full)
          stuff_err <= 1'b1;
        else begin
          d_orig        <= w_dec;
          bit_valid     <= 1'b1;
          byte_received <= r_bit_cnt == 3'd7;
          r_bit_cnt     <= r_bit_cnt + 1'b1;
          r_ones        <= w_dec ? r_ones + 1'b1 : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_bit_sampler.sv
// tb_usb_rx_bit_sampler: scoreboard bench; line stimulus pushes expected decoded bits,
// a negedge monitor pops them on each bit_valid and checks value, byte flag and timing.
module tb_usb_rx_bit_sampler;
  localparam int CPB = 8;
  localparam int SP  = 3;
  localparam int SL  = 6;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic d_plus_sync = 1'b1;
  logic d_edge = 1'b0;
  logic rcving = 1'b0;
  logic d_orig, bit_valid, byte_received, stuff_err;
  typedef struct {logic d; logic b; int t;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int ones = 0;
  int cnt = 0;
  logic line = 1'b1;
  logic pl = 1'b1;
  logic m_err = 1'b0;
  logic prev_bv = 1'b0;

  usb_rx_bit_sampler #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .STUFF_LIMIT(SL)) dut (
    .clk(clk), .n_rst(n_rst), .d_plus_sync(d_plus_sync), .d_edge(d_edge), .rcving(rcving),
    .d_orig(d_orig), .bit_valid(bit_valid), .byte_received(byte_received), .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (n_rst) begin
      if (bit_valid) begin
        checks++;
        nvalid++;
        if (prev_bv) begin
          errors++;
          $display("FAIL strobe_width: bit_valid high in consecutive cycles at cyc %0d", cyc);
        end else if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: d_orig=%b byte_received=%b at cyc %0d, no bit expected", d_orig, byte_received, cyc);
        end else begin
          e = sbq.pop_front();
          if (d_orig !== e.d || byte_received !== e.b || (e.t >= 0 && cyc != e.t)) begin
            errors++;
            $display("FAIL bit: got d_orig=%b byte_received=%b cyc=%0d, expected d_orig=%b byte_received=%b cyc=%0d",
                     d_orig, byte_received, cyc, e.d, e.b, e.t);
          end
        end
      end else if (byte_received) begin
        checks++;
        errors++;
        $display("FAIL byte_without_bit: byte_received=1 bit_valid=0 at cyc %0d", cyc);
      end
    end
    prev_bv = bit_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_dec(input logic b, input int per);
    logic lvl;
    lvl = b ? pl : ~pl;
    d_plus_sync = lvl;
    d_edge = lvl != line;
    if (ones == SL && !b) ones = 0;
    else if (ones == SL) m_err = 1'b1;
    else begin
      sbq.push_back('{b, cnt == 7, (lvl != line) ? cyc + SP + 2 : -1});
      cnt = (cnt + 1) % 8;
      ones = b ? ones + 1 : 0;
    end
    line = lvl;
    pl = lvl;
    tick();
    d_edge = 1'b0;
    repeat (per - 1) tick();
  endtask

  task automatic send_sync(input int pe, input int po);
    for (int i = 0; i < 8; i++) send_dec(i == 7, (i % 2) ? po : pe);
  endtask

  task automatic end_pkt();
    rcving = 1'b0;
    d_edge = line != 1'b1;
    d_plus_sync = 1'b1;
    line = 1'b1;
    pl = 1'b1;
    ones = 0;
    cnt = 0;
    m_err = 1'b0;
    tick();
    d_edge = 1'b0;
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_bits: %0d expected bits never strobed, required 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({d_orig, bit_valid, byte_received, stuff_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: outputs=%b, required 1000", {d_orig, bit_valid, byte_received, stuff_err});
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    int n0;
    n0 = nvalid;
    for (int i = 0; i < 4; i++) begin
      d_plus_sync = ~line;
      line = ~line;
      d_edge = 1'b1;
      tick();
      d_edge = 1'b0;
      repeat (9) tick();
    end
    checks++;
    if (nvalid != n0 || stuff_err !== 1'b0) begin
      errors++;
      $display("FAIL idle: strobes=%0d stuff_err=%b, required 0 and 0", nvalid - n0, stuff_err);
    end
  endtask

  task automatic test_sync();
    int n0;
    n0 = nvalid;
    rcving = 1'b1;
    send_sync(CPB, CPB);
    checks++;
    if (nvalid - n0 != 8) begin
      errors++;
      $display("FAIL sync_count: strobes=%0d, required 8", nvalid - n0);
    end
    end_pkt();
  endtask

  task automatic test_stuffing();
    int n0;
    n0 = nvalid;
    rcving = 1'b1;
    send_sync(CPB, CPB);
    send_dec(1'b0, CPB);
    repeat (6) send_dec(1'b1, CPB);
    send_dec(1'b0, CPB);
    send_dec(1'b0, CPB);
    checks++;
    if (nvalid - n0 != 16 || stuff_err !== 1'b0) begin
      errors++;
      $display("FAIL stuffing: strobes=%0d stuff_err=%b, required 16 and 0", nvalid - n0, stuff_err);
    end
    end_pkt();
  endtask

  task automatic test_stuff_err();
    int n0;
    rcving = 1'b1;
    send_sync(CPB, CPB);
    send_dec(1'b0, CPB);
    repeat (6) send_dec(1'b1, CPB);
    checks++;
    if (stuff_err !== 1'b0) begin
      errors++;
      $display("FAIL stuff_err_early: stuff_err=%b, required 0", stuff_err);
    end
    n0 = nvalid;
    send_dec(1'b1, CPB);
    checks++;
    if (stuff_err !== 1'b1 || m_err !== 1'b1 || nvalid != n0) begin
      errors++;
      $display("FAIL stuff_err_set: stuff_err=%b strobes=%0d, required 1 and 0", stuff_err, nvalid - n0);
    end
    send_dec(1'b1, CPB);
    checks++;
    if (stuff_err !== 1'b1 || nvalid != n0) begin
      errors++;
      $display("FAIL stuff_err_sticky: stuff_err=%b strobes=%0d, required 1 and 0", stuff_err, nvalid - n0);
    end
    rcving = 1'b0;
    tick();
    checks++;
    if (stuff_err !== 1'b0 || d_orig !== 1'b1) begin
      errors++;
      $display("FAIL stuff_err_clear: stuff_err=%b d_orig=%b, required 0 and 1", stuff_err, d_orig);
    end
    end_pkt();
  endtask

  task automatic test_jitter();
    rcving = 1'b1;
    send_sync(CPB - 1, CPB + 1);
    end_pkt();
  endtask

  task automatic test_abort();
    rcving = 1'b1;
    send_sync(CPB, CPB);
    for (int i = 0; i < 5; i++) send_dec(1'($urandom_range(0, 1)), CPB);
    end_pkt();
    tick();
    rcving = 1'b1;
    send_sync(CPB, CPB);
    end_pkt();
  endtask

  task automatic test_back_to_back();
    rcving = 1'b1;
    send_sync(CPB, CPB);
    for (int i = 0; i < 16; i++) send_dec(1'($urandom_range(0, 1)), CPB);
    end_pkt();
  endtask

  task automatic test_reset_mid();
    rcving = 1'b1;
    for (int i = 0; i < 3; i++) send_dec(1'b0, CPB);
    d_plus_sync = ~pl;
    d_edge = 1'b1;
    line = ~pl;
    pl = ~pl;
    tick();
    d_edge = 1'b0;
    tick();
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({d_orig, bit_valid, byte_received, stuff_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async: outputs=%b, required 1000", {d_orig, bit_valid, byte_received, stuff_err});
    end
    sbq.delete();
    cnt = 0;
    ones = 0;
    pl = 1'b1;
    line = 1'b0;
    d_plus_sync = 1'b0;
    rcving = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    rcving = 1'b1;
    send_sync(CPB, CPB);
    end_pkt();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_sync();
    test_stuffing();
    test_stuff_err();
    test_jitter();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_rx_bit_sampler.md
# usb_rx_bit_sampler

Bit-timing recovery and line-decoding stage of the USB receive path. It sits directly downstream of the D+ edge detector and consumes its synchronized line value and edge pulse. It re-phases an internal bit clock on every edge, samples each bit mid-period, NRZI-decodes it and strips stuffed bits. Its output is a qualified bit stream with per-bit strobes and byte boundaries, which feeds the receive shift register and the RX control FSM.

## Interface
- CLKS_PER_BIT, 8, nominal clocks per USB bit period; legal range 4–16.
- SAMPLE_POINT, 3, phase-counter value at which the line is sampled; must be < CLKS_PER_BIT.
- STUFF_LIMIT, 6, consecutive decoded 1s after which a stuffed 0 is expected.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- d_plus_sync  in  1  synchronized D+ level from the edge detector; idle J = 1.
- d_edge  in  1  one-cycle pulse when d_plus_sync changed.
- rcving  in  1  receive enable from the RX control FSM; low = idle/clear.
- d_orig  out  1  last decoded, unstuffed data bit.
- bit_valid  out  1  one-cycle strobe; d_orig holds a new data bit.
- byte_received  out  1  one-cycle strobe coincident with the 8th bit_valid of a byte.
- stuff_err  out  1  sticky: more than STUFF_LIMIT consecutive 1s seen.

## Operation
- Reset values: d_orig=1, bit_valid=0, byte_received=0, stuff_err=0. Internal state after reset: phase=0, prev_level=1, ones_cnt=0, bit_cnt=0.
- rcving=0:
  - All internal state returns to its reset values on the next edge.
  - Outputs return to their reset values on the next edge, including stuff_err.
  - The phase counter is held at 0.
- rcving=1, phase counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - d_edge=1 forces phase to 0 on the next edge, and takes priority over increment and wrap.
- Sample event: a sample is taken when phase==SAMPLE_POINT and rcving=1, including the cycle where d_edge=1.
  - decoded = ~(d_plus_sync ^ prev_level), NRZI: no transition = 1.
  - prev_level <= d_plus_sync.
- Stuffed bit (ones_cnt==STUFF_LIMIT and decoded==0):
  - The bit is discarded and ones_cnt is set to 0.
  - No bit_valid is issued and bit_cnt is unchanged.
- Stuff error (ones_cnt==STUFF_LIMIT and decoded==1):
  - stuff_err is set; it is sticky until rcving=0 or reset.
  - The bit is discarded with no bit_valid; ones_cnt stays at STUFF_LIMIT.
- Normal bit (all other samples):
  - d_orig <= decoded and bit_valid pulses.
  - ones_cnt <= decoded ? ones_cnt+1 : 0.
  - bit_cnt increments modulo 8; when it wraps from 7 to 0, byte_received pulses together with bit_valid.
- Width rules: phase is wide enough for CLKS_PER_BIT-1; ones_cnt is wide enough for STUFF_LIMIT; bit_cnt is 3 bits.
- Bits are delivered LSB-first exactly as received. Byte assembly happens downstream.
- Asynchronous reset mid-packet: all state clears immediately. No strobe is emitted for a partial byte.

## Timing
- d_edge high in cycle E: phase=0 in E+1, sample in E+1+SAMPLE_POINT, bit_valid high in E+2+SAMPLE_POINT (registered outputs).
- With no further edges, subsequent samples follow every CLKS_PER_BIT cycles.
- Tolerance: bit periods of CLKS_PER_BIT±1 clocks that are delimited by edges must decode correctly, because each edge re-phases the counter.
- bit_valid and byte_received are each exactly 1 cycle wide, and never high in consecutive cycles while CLKS_PER_BIT≥2.
- rcving falling: bit_valid, byte_received, stuff_err and d_orig are at reset values by the cycle after rcving is sampled low. A sample coinciding with the rcving=0 cycle is dropped.
- rcving rising: the phase counter leaves 0 in the first cycle rcving=1, so the first sample falls SAMPLE_POINT cycles later unless an edge re-phases the counter.

## Test plan
- SYNC, 8 clk/bit: rcving=1, drive d_plus_sync 0,1,0,1,0,1,0,0 with matching d_edge pulses → 8 bit_valid strobes with d_orig=0,0,0,0,0,0,0,1, and byte_received on the 8th.
- Stuffing: after SYNC, send line data decoding to six 1s, a stuffed 0, then 0 → 7 bit_valid strobes (1×6, then 0); stuff_err=0; bit_cnt is not advanced by the stuffed bit.
- Stuff error: decoded seven consecutive 1s → stuff_err=1 from the cycle after the 7th sample, no 7th bit_valid; stuff_err returns to 0 one cycle after rcving=0.
- Jitter: SYNC with alternating bit periods of 7 and 9 clocks → same 8 decoded bits as the nominal case, each bit_valid at edge+SAMPLE_POINT+2.
- Abort: rcving drops after 5 bits of a byte → no byte_received; the next packet's SYNC yields byte_received after exactly 8 new bits.
- Reset mid-packet: n_rst pulsed low during bit 4 → all outputs at reset values asynchronously; the first sample after reset uses prev_level=1.
